// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per valid/ready handshake, sent as start, 8 data bits LSB first, parity, stop.
// The Tx output is registered and changes only on the accept edge or on a bit boundary.
module uart_transmitter #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 50000000,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        enable,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        ready,
  output logic        Tx,
  output logic        tx_done,
  output logic        transmitting,
  output logic [3:0]  bits_sent,
  output logic [15:0] BAUD_counter
);

  localparam int          CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam logic [15:0] LAST_CNT     = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [8:0]  shreg_q, shreg_d;
  logic [3:0]  bits_q, bits_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;
  logic        wrap;

  assign wrap = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    bits_d  = bits_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (enable) begin
      if (state_q == IDLE) begin
        if (data_valid) begin
          shreg_d = {^data_in ^ PARITY_ODD, data_in};
          cnt_d   = '0;
          bits_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end else begin
        cnt_d = wrap ? 16'd0 : cnt_q + 16'd1;
        if (wrap) begin
          case (state_q)
            START: begin
              tx_d    = shreg_q[0];
              state_d = DATA;
            end
            // Next bit on the line is shreg_q[1]; after the 8th data bit that is the parity bit.
            DATA: begin
              shreg_d = {1'b0, shreg_q[8:1]};
              tx_d    = shreg_q[1];
              bits_d  = bits_q + 4'd1;
              if (bits_q == 4'd7) state_d = PARITY;
            end
            PARITY: begin
              bits_d  = 4'd9;
              tx_d    = 1'b1;
              state_d = STOP;
            end
            STOP: begin
              bits_d  = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
            default: state_d = IDLE;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      bits_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      bits_q  <= bits_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign ready        = (state_q == IDLE);
  assign transmitting = (state_q != IDLE);
  assign Tx           = tx_q;
  assign tx_done      = done_q;
  assign bits_sent    = bits_q;
  assign BAUD_counter = cnt_q;

endmodule
